// File: rtl/approx_prefix_adder_pipe.sv
// Two-stage Kogge-Stone adder with optional lower-part-OR approximation of the
// low APPROX_BITS bits. Stall-all pipeline with valid/ready on both sides.
module approx_prefix_adder_pipe #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_approx
);

  localparam int LVLS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] LO_MASK =
    (APPROX_BITS == 0) ? '0 : ({WIDTH{1'b1}} >> (WIDTH - APPROX_BITS));
  localparam logic [WIDTH-1:0] TOP_MASK = LO_MASK & ~(LO_MASK >> 1);

  logic adv;

  logic             vld_p1_d, vld_p1_q;
  logic [WIDTH-1:0] g_p1_d, g_p1_q;
  logic [WIDTH-1:0] p_p1_d, p_p1_q;
  logic [WIDTH-1:0] or_p1_d, or_p1_q;
  logic             cin_p1_d, cin_p1_q;
  logic             apx_p1_d, apx_p1_q;

  logic             vld_p2_d, vld_p2_q;
  logic [WIDTH-1:0] sum_p2_d, sum_p2_q;
  logic             cout_p2_d, cout_p2_q;
  logic             apx_p2_d, apx_p2_q;

  logic             lo_en;
  logic             c0;
  logic [WIDTH-1:0] gl, pl, gn, pn;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_raw;

  assign adv      = !vld_p2_q | out_ready;
  assign in_ready = adv;

  // Stage 1 boundary: bitwise generate/propagate and the low-part OR vector
  always_comb begin
    vld_p1_d = vld_p1_q;
    g_p1_d   = g_p1_q;
    p_p1_d   = p_p1_q;
    or_p1_d  = or_p1_q;
    cin_p1_d = cin_p1_q;
    apx_p1_d = apx_p1_q;
    if (adv) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        g_p1_d   = a & b;
        p_p1_d   = a ^ b;
        or_p1_d  = a | b;
        cin_p1_d = cin;
        apx_p1_d = approx_en;
      end
    end
  end

  // Stage 2 boundary: prefix tree over the (possibly masked) low slice
  always_comb begin
    lo_en = apx_p1_q && (APPROX_BITS != 0);
    // In LOA mode the low slice only contributes g[k-1] as the carry into bit k.
    gl = lo_en ? ((g_p1_q & ~LO_MASK) | (g_p1_q & TOP_MASK)) : g_p1_q;
    pl = lo_en ? (p_p1_q & ~LO_MASK) : p_p1_q;
    c0 = lo_en ? 1'b0 : cin_p1_q;
    gn = gl;
    pn = pl;
    for (int lv = 0; lv < LVLS; lv++) begin
      gn = gl;
      pn = pl;
      for (int i = (1 << lv); i < WIDTH; i++) begin
        gn[i] = gl[i] | (pl[i] & gl[i - (1 << lv)]);
        pn[i] = pl[i] & pl[i - (1 << lv)];
      end
      gl = gn;
      pl = pn;
    end
    carry[0] = c0;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = gl[i] | (pl[i] & c0);
    end
    sum_raw = p_p1_q ^ carry[WIDTH-1:0];
    if (lo_en) begin
      sum_raw = (sum_raw & ~LO_MASK) | (or_p1_q & LO_MASK);
    end

    vld_p2_d  = vld_p2_q;
    sum_p2_d  = sum_p2_q;
    cout_p2_d = cout_p2_q;
    apx_p2_d  = apx_p2_q;
    if (adv) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        sum_p2_d  = sum_raw;
        cout_p2_d = carry[WIDTH];
        apx_p2_d  = apx_p1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    g_p1_q   <= g_p1_d;
    p_p1_q   <= p_p1_d;
    or_p1_q  <= or_p1_d;
    cin_p1_q <= cin_p1_d;
    apx_p1_q <= apx_p1_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      sum_p2_q  <= '0;
      cout_p2_q <= 1'b0;
      apx_p2_q  <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      sum_p2_q  <= sum_p2_d;
      cout_p2_q <= cout_p2_d;
      apx_p2_q  <= apx_p2_d;
    end
  end

  assign out_valid  = vld_p2_q;
  assign sum        = sum_p2_q;
  assign cout       = cout_p2_q;
  assign out_approx = apx_p2_q;

endmodule

// File: doc/approx_prefix_adder_pipe.md
Name: approx_prefix_adder_pipe

Overview:
- Parametrised, 2-stage pipelined Kogge-Stone prefix adder.
- Each transaction selects one of two modes:
  - exact add;
  - lower-part-OR approximate (LOA) add, with the low APPROX_BITS bits approximated.
- Successor to the single-bit full-adder cell. Used as the adder datapath in the approximate-arithmetic evaluation builds.
- Valid/ready handshake on input and output; full backpressure support.

Parameters:
- WIDTH, 16, operand/sum width in bits; legal 2..64.
- APPROX_BITS, 4, low bits computed approximately in approx mode; legal 0..WIDTH-1; 0 means approx mode behaves exactly.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand transaction present
- in_ready  output  1  block accepts a transaction this cycle
- a  input  WIDTH  operand A (unsigned)
- b  input  WIDTH  operand B (unsigned)
- cin  input  1  carry-in
- approx_en  input  1  1 = LOA mode, 0 = exact mode; sampled with operands
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result sum
- cout  output  1  result carry-out
- out_approx  output  1  approx_en of the transaction now on the output

Behaviour:
- Reset: one clock with rst=1 clears s1_valid, s2_valid, out_valid, sum, cout and out_approx to 0.
  - Reset mid-operation discards all in-flight transactions; nothing is emitted afterwards.
  - in_ready is combinational: it may be 1 during reset, but transfers are ignored while rst=1.
- Global advance enable: adv = !out_valid | out_ready. in_ready = adv.
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Pipeline: all registers update only when adv=1; when adv=0 every stage holds. Bubbles are not compressed (stall-all pipeline).
- Stage 1 (registered on accept), per bit i:
  - g[i] = a[i]&b[i]; p[i] = a[i]^b[i].
  - Also register approx_en, cin, and the low-part OR vector a|b.
  - s1_valid <= in_valid & in_ready.
- Stage 2 (registered):
  - log2ceil(WIDTH)-level Kogge-Stone group-G/P computation.
  - Produces the sum, cout and out_approx presented on the outputs.
  - out_valid <= s1_valid.
- Latency: exactly 2 cycles from input transfer to out_valid, with no stalls. Throughput: 1 per cycle while out_ready=1.
- Exact mode (approx_en=0):
  - {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1).
- Approx mode (approx_en=1, APPROX_BITS=k>0):
  - sum[k-1:0] = a[k-1:0] | b[k-1:0].
  - Carry into bit k = a[k-1] & b[k-1].
  - cin is ignored.
  - Bits k..WIDTH-1 and cout: exact prefix add of the upper slices plus that carry.
- approx_en with APPROX_BITS=0: result identical to exact mode, including cin; out_approx still reflects approx_en.
- Outputs are stable while out_valid=1 and out_ready=0.
- in_valid/operands may change freely when in_ready=0; they are not captured.
- Simultaneous in and out transfer in the same cycle is legal and is the steady-state case.

Test Plan (WIDTH=16, APPROX_BITS=4 unless stated):
- Carry propagation, both modes:
  - Stimulus: a=0x000F, b=0x0001, cin=0, approx_en=0, then the same operands with approx_en=1.
  - Response: exact gives sum=0x0010, cout=0; approx gives sum=0x000F, cout=0, out_approx=1. Each result appears 2 cycles after its accept.
- LOA carry generation:
  - Stimulus: a=0x0008, b=0x0008, approx_en=1.
  - Response: sum=0x0018, cout=0 (exact mode would give 0x0010).
- Overflow and cin:
  - Stimulus: a=0xFFFF, b=0x0001, cin=0, exact → sum=0x0000, cout=1.
  - Stimulus: a=0xFFFF, b=0x0000, cin=1, approx → cin ignored → sum=0xFFFF, cout=0.
  - Stimulus: a=0xFFFF, b=0x0000, cin=1, exact → sum=0x0000, cout=1.
- Backpressure:
  - Stimulus: stream 5 back-to-back random transactions; hold out_ready=0 for 3 cycles starting when the first result is valid.
  - Response: in_ready=0 during the stall; output held unchanged; all 5 results emitted in order, none lost or duplicated; results match the reference model.
- Reset mid-flight:
  - Stimulus: accept 2 transactions, then assert rst for 1 cycle on the cycle after the second accept.
  - Response: out_valid=0 the cycle after reset and stays 0 until new input; sum=0, cout=0.
- Parameter sweep:
  - Configurations: WIDTH=8/APPROX_BITS=0, WIDTH=32/APPROX_BITS=8, WIDTH=64/APPROX_BITS=63.
  - Stimulus: 10k random transactions with random valid/ready.
  - Response: bit-exact match to the model in both modes.
